// File: rtl/register_file_mp_pkg.sv
// Shared types for the multi-port integer register file: data width,
// register address type, write-control bundle, clear-FSM states and the
// write-port priority helper used by every bank.
package rf_pkg;

   localparam int XLEN          = 32;
   localparam int NUM_REGS      = 32;
   localparam int REG_AW        = $clog2(NUM_REGS);
   localparam int RF_MAX_WPORTS = 2;

   typedef logic [REG_AW-1:0] rv_reg_t;

   typedef struct packed {
      logic            enable;
      rv_reg_t         which_register;
      logic [XLEN-1:0] value;
   } reg_write_control_t;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   // Result of the write-port priority search: did any port write the
   // target register, and which port won.
   typedef struct packed {
      logic hit;
      logic idx;
   } rf_fwd_t;

   // Higher-numbered ports override lower ones, matching the order in which
   // the storage array applies its writes. Writes to x0 never hit.
   function automatic rf_fwd_t rf_fwd_select(
      input logic    [RF_MAX_WPORTS-1:0] en,
      input rv_reg_t [RF_MAX_WPORTS-1:0] regs,
      input rv_reg_t                     target
   );
      rf_fwd_t r;
      r = '0;
      for (int p = 0; p < RF_MAX_WPORTS; p++) begin
         if (en[p] && (regs[p] == target) && (target != '0)) begin
            r.hit = 1'b1;
            r.idx = 1'(p);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Register-file bus: read addresses and write controls in, read data and
// ready out.
// Handshake: there is no valid/ready pair per transaction. rs is sampled on
// every rising edge and its data appears one cycle later; write_control is
// applied on the edge it is presented at, but only while ready is high.
// Anything presented while ready is low is dropped.
interface register_file_mp_if #(
   parameter int NUM_READ_PORTS  = 2,
   parameter int NUM_WRITE_PORTS = 1
) ();
   import rf_pkg::*;

   rv_reg_t            [NUM_READ_PORTS-1:0]  rs;
   reg_write_control_t [NUM_WRITE_PORTS-1:0] write_control;
   logic [NUM_READ_PORTS-1:0][XLEN-1:0]      rs_val;
   logic                                     ready;

   // Pipeline side: decode drives rs, writeback drives write_control.
   modport master (
      output rs,
      output write_control,
      input  rs_val,
      input  ready
   );

   // Register file side.
   modport slave (
      input  rs,
      input  write_control,
      output rs_val,
      output ready
   );

endinterface

// File: rtl/register_file_mp_bank.sv
// One storage copy serving a single read port. Every bank sees every write
// port, so all copies stay identical. The read is registered (BRAM-style),
// and a write landing on the same edge as the read is forwarded so the
// reader sees the new value.
module register_file_mp_bank
   import rf_pkg::*;
#(
   parameter int NUM_REGS        = rf_pkg::NUM_REGS,
   parameter int NUM_WRITE_PORTS = 1
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     run,
   input  rv_reg_t                                  rs,
   input  reg_write_control_t [NUM_WRITE_PORTS-1:0] wc,
   output logic [XLEN-1:0]                          rs_val
);

   logic [XLEN-1:0] mem [NUM_REGS];

   logic [XLEN-1:0] last_mem;
   rv_reg_t         last_rs;
   logic            last_run;
   logic            last_hit;
   logic [XLEN-1:0] last_val;

   logic    [RF_MAX_WPORTS-1:0]           w_en;
   rv_reg_t [RF_MAX_WPORTS-1:0]           w_reg;
   logic    [RF_MAX_WPORTS-1:0][XLEN-1:0] w_val;
   rf_fwd_t                               sel;

   // Pad the write ports to the fixed width the priority helper expects.
   always_comb begin
      w_en  = '0;
      w_reg = '0;
      w_val = '0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
         w_en[p]  = wc[p].enable;
         w_reg[p] = wc[p].which_register;
         w_val[p] = wc[p].value;
      end
      sel = rf_fwd_select(w_en, w_reg, rs);
   end

   // Storage has no reset: the clear sweep zeroes it. The read captures the
   // pre-write contents; later ports overwrite earlier ones on conflict.
   always_ff @(posedge clock) begin
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
         if (wc[p].enable && (wc[p].which_register != '0)) begin
            mem[wc[p].which_register] <= wc[p].value;
         end
      end
      last_mem <= mem[rs];
   end

   // Capture the read address and the winning same-edge write for forwarding.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_rs  <= '0;
         last_run <= 1'b0;
         last_hit <= 1'b0;
         last_val <= '0;
      end else begin
         last_rs  <= rs;
         last_run <= run;
         last_hit <= sel.hit & run;
         last_val <= w_val[sel.idx];
      end
   end

   // x0, reads captured during the sweep and reset all read as zero.
   always_comb begin
      rs_val = '0;
      if (!reset && last_run && (last_rs != '0)) begin
         rs_val = last_hit ? last_val : last_mem;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file. After reset a hardware sweep writes
// zero into x1..x(NUM_REGS-1) of every bank; ready rises when it finishes
// and user writes are accepted from then on.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int NUM_REGS        = rf_pkg::NUM_REGS,
   parameter int NUM_READ_PORTS  = 2,
   parameter int NUM_WRITE_PORTS = 1
) (
   input  logic                clock,
   input  logic                reset,
   register_file_mp_if.slave   rf,
   output rf_state_t           state_dbg
);

   localparam rv_reg_t LAST_PTR = rv_reg_t'(NUM_REGS - 1);

   rf_state_t state;
   rf_state_t state_next;
   rv_reg_t   clear_ptr;
   rv_reg_t   clear_ptr_next;
   logic      run;

   reg_write_control_t [NUM_WRITE_PORTS-1:0]      bank_wc;
   logic [NUM_READ_PORTS-1:0][XLEN-1:0]           rs_val_w;

   // Clear FSM state register; reset always restarts the sweep at x1.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RF_CLEAR;
         clear_ptr <= rv_reg_t'(1);
      end else begin
         state     <= state_next;
         clear_ptr <= clear_ptr_next;
      end
   end

   // Sweep one register per cycle; RUN is terminal until the next reset.
   always_comb begin
      state_next     = state;
      clear_ptr_next = clear_ptr;
      case (state)
         RF_CLEAR: begin
            clear_ptr_next = clear_ptr + rv_reg_t'(1);
            if (clear_ptr == LAST_PTR) begin
               state_next = RF_RUN;
            end
         end
         RF_RUN: begin
            state_next = RF_RUN;
         end
         default: begin
            state_next = RF_CLEAR;
         end
      endcase
   end

   assign run       = (state == RF_RUN) && !reset;
   assign rf.ready  = run;
   assign state_dbg = state;

   // Bank write ports: user writes in RUN, the zeroing sweep on port 0 in
   // CLEAR, nothing otherwise (so CLEAR-time user writes are discarded).
   always_comb begin
      bank_wc = '0;
      if (run) begin
         bank_wc = rf.write_control;
      end else if ((state == RF_CLEAR) && !reset) begin
         bank_wc[0].enable         = 1'b1;
         bank_wc[0].which_register = clear_ptr;
         bank_wc[0].value          = '0;
      end
   end

   for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : gen_bank
      register_file_mp_bank #(
         .NUM_REGS        (NUM_REGS),
         .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
      ) u_bank (
         .clock  (clock),
         .reset  (reset),
         .run    (run),
         .rs     (rf.rs[i]),
         .wc     (bank_wc),
         .rs_val (rs_val_w[i])
      );
   end

   assign rf.rs_val = rs_val_w;

`ifdef SIMULATION
   // Debug taps into bank 0's capture registers.
   rv_reg_t         dbg_bank0_last_rs;
   logic            dbg_bank0_last_hit;
   logic [XLEN-1:0] dbg_bank0_last_val;
   assign dbg_bank0_last_rs  = gen_bank[0].u_bank.last_rs;
   assign dbg_bank0_last_hit = gen_bank[0].u_bank.last_hit;
   assign dbg_bank0_last_val = gen_bank[0].u_bank.last_val;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with two read and two write ports.
module tb_register_file_mp;
   import rf_pkg::*;

   logic      clock;
   logic      reset;
   rf_state_t state_dbg;

   int vectors;
   int miscompares;

   register_file_mp_if #(.NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2)) rf_bus ();

   register_file_mp #(
      .NUM_REGS        (32),
      .NUM_READ_PORTS  (2),
      .NUM_WRITE_PORTS (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rf        (rf_bus),
      .state_dbg (state_dbg)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_wr(input int p, input logic en, input rv_reg_t r, input logic [31:0] v);
      rf_bus.write_control[p] = '{enable: en, which_register: r, value: v};
   endtask

   task automatic clear_wr();
      set_wr(0, 1'b0, '0, '0);
      set_wr(1, 1'b0, '0, '0);
   endtask

   task automatic set_rd(input rv_reg_t r0, input rv_reg_t r1);
      rf_bus.rs[0] = r0;
      rf_bus.rs[1] = r1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      clear_wr();
      set_rd(5'd5, 5'd6);

      // 1: reset, then sweep of 31 cycles with ready low and reads zero
      repeat (3) tick();
      check("reset_ready", 32'(rf_bus.ready), 32'd0);
      check("reset_rs0", rf_bus.rs_val[0], 32'd0);
      check("reset_rs1", rf_bus.rs_val[1], 32'd0);
      reset = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("sweep_ready", 32'(rf_bus.ready), (i == 31) ? 32'd1 : 32'd0);
         check("sweep_rs0", rf_bus.rs_val[0], 32'd0);
         check("sweep_rs1", rf_bus.rs_val[1], 32'd0);
      end

      // 2: write x5, stale x7 reads zero, then x5 reads back
      set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      set_rd(5'd7, 5'd31);
      tick();
      check("stale_x7", rf_bus.rs_val[0], 32'd0);
      check("stale_x31", rf_bus.rs_val[1], 32'd0);
      clear_wr();
      set_rd(5'd5, 5'd7);
      tick();
      check("read_x5", rf_bus.rs_val[0], 32'hDEAD_BEEF);
      check("read_x7", rf_bus.rs_val[1], 32'd0);

      // 3: same-cycle write and duplicate reads of x3 see the new value
      set_wr(0, 1'b1, 5'd3, 32'h0000_1234);
      set_rd(5'd3, 5'd3);
      tick();
      check("fwd_x3_p0", rf_bus.rs_val[0], 32'h0000_1234);
      check("fwd_x3_p1", rf_bus.rs_val[1], 32'h0000_1234);
      clear_wr();
      tick();
      check("store_x3_p0", rf_bus.rs_val[0], 32'h0000_1234);
      check("store_x3_p1", rf_bus.rs_val[1], 32'h0000_1234);

      // 4: x0 writes are dropped, forwarded or not
      set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      set_rd(5'd0, 5'd5);
      tick();
      check("x0_same", rf_bus.rs_val[0], 32'd0);
      check("x5_kept", rf_bus.rs_val[1], 32'hDEAD_BEEF);
      clear_wr();
      tick();
      check("x0_next", rf_bus.rs_val[0], 32'd0);

      // 5: two ports hit x9, port 1 wins; x31 boundary register
      set_wr(0, 1'b1, 5'd9, 32'h0000_000A);
      set_wr(1, 1'b1, 5'd9, 32'h0000_000B);
      set_rd(5'd9, 5'd9);
      tick();
      check("prio_fwd_p0", rf_bus.rs_val[0], 32'h0000_000B);
      check("prio_fwd_p1", rf_bus.rs_val[1], 32'h0000_000B);
      set_wr(0, 1'b1, 5'd31, 32'h8000_0001);
      set_wr(1, 1'b0, 5'd0, 32'd0);
      tick();
      check("prio_store", rf_bus.rs_val[0], 32'h0000_000B);
      clear_wr();
      set_rd(5'd31, 5'd3);
      tick();
      check("read_x31", rf_bus.rs_val[0], 32'h8000_0001);
      check("read_x3_again", rf_bus.rs_val[1], 32'h0000_1234);

      // 6: fill, restart sweep, abort at ptr 10, write during CLEAR is lost
      for (int r = 1; r <= 31; r++) begin
         set_wr(0, 1'b1, rv_reg_t'(r), 32'hFFFF_FFFF);
         tick();
      end
      clear_wr();
      set_rd(5'd17, 5'd1);
      tick();
      check("fill_x17", rf_bus.rs_val[0], 32'hFFFF_FFFF);
      check("fill_x1", rf_bus.rs_val[1], 32'hFFFF_FFFF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (9) tick();
      check("mid_sweep_ready", 32'(rf_bus.ready), 32'd0);
      reset = 1'b1;
      tick();
      check("abort_ready", 32'(rf_bus.ready), 32'd0);
      check("abort_rs0", rf_bus.rs_val[0], 32'd0);
      reset = 1'b0;
      set_wr(0, 1'b1, 5'd4, 32'h0000_0055);
      set_rd(5'd4, 5'd4);
      for (int i = 1; i <= 31; i++) begin
         tick();
         if (i == 5) clear_wr();
         check("resweep_ready", 32'(rf_bus.ready), (i == 31) ? 32'd1 : 32'd0);
      end
      for (int r = 0; r < 32; r += 2) begin
         set_rd(rv_reg_t'(r), rv_reg_t'(r + 1));
         tick();
         check("cleared_even", rf_bus.rs_val[0], 32'd0);
         check("cleared_odd", rf_bus.rs_val[1], 32'd0);
      end

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
